// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and the instruction RAM.
package imem_loader_pkg;

  localparam int          IMEM_DEPTH    = 1024;
  localparam int          IMEM_ADDR_W   = 10;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the boot loader.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) ();

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  // The loader masters the RAM write bus and sinks the receiver's byte stream.
  modport master (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_waddr, mem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles four little-endian bytes into one 32-bit word; the word is presented
// combinationally alongside the fourth byte so the caller can register it.
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] buf_q, buf_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    lane_d = lane_q;
    buf_d  = buf_q;
    if (clear_i) begin
      lane_d = 2'd0;
    end else if (byte_valid_i) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    buf_d[7:0]   = byte_i;
        2'd1:    buf_d[15:8]  = byte_i;
        2'd2:    buf_d[23:16] = byte_i;
        default: buf_d        = buf_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      lane_q <= 2'd0;
      buf_q  <= '0;
    end else begin
      lane_q <= lane_d;
      buf_q  <= buf_d;
    end
  end

  assign word_valid_o = byte_valid_i && !clear_i && (lane_q == 2'd3);
  assign word_o       = {byte_i, buf_q};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses sync/count/word frames from a byte stream, writes the
// instruction RAM and holds the CPU in reset until a load completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         DEPTH     = IMEM_DEPTH,
  parameter int         ADDR_W    = IMEM_ADDR_W,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         TIMEOUT   = 1000000,
  parameter bit         BOOT_HOLD = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err,
  output logic [15:0]   words_written
);

  localparam int              TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT);
  localparam logic [16:0]     DEPTH_17 = 17'(DEPTH);

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       idx_q, idx_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       ww_q, ww_d;

  logic        accept;
  logic        word_valid;
  logic [31:0] word;

  assign accept = bus.in_valid;

  imem_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (state_q != ST_DATA),
    .byte_valid_i (accept && (state_q == ST_DATA)),
    .byte_i       (bus.in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    to_d    = to_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    ww_d    = ww_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (accept && bus.in_data == SYNC_BYTE) begin
          state_d = ST_LEN_LO;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          ww_d    = '0;
          to_d    = '0;
        end else if (state_q == ST_DONE) begin
          // One cycle after the final write, so the CPU only sees committed memory.
          done_d = 1'b1;
          hold_d = 1'b0;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          count_d[7:0] = bus.in_data;
          state_d      = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          count_d[15:8] = bus.in_data;
          idx_d         = '0;
          state_d       = ({bus.in_data, count_q[7:0]} == 16'd0) ? ST_DONE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_valid) begin
          if ({1'b0, idx_q} < DEPTH_17) begin
            we_d    = 1'b1;
            waddr_d = idx_q[ADDR_W-1:0];
            wdata_d = word;
            if ({1'b0, ww_q} < DEPTH_17) ww_d = ww_q + 16'd1;
          end
          idx_d = idx_q + 16'd1;
          if (idx_q == count_q - 16'd1) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Inter-byte watchdog; only runs while a frame is open.
    if (state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA}) begin
      if (accept) begin
        to_d = '0;
      end else begin
        to_d = to_q + 1'b1;
        if (to_d == TO_MAX) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          to_d    = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      to_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= BOOT_HOLD;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ww_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ww_q    <= ww_d;
    end
  end

  assign bus.in_ready  = 1'b1;
  assign bus.mem_we    = we_q;
  assign bus.mem_waddr = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_hold      = hold_q;
  assign load_done     = done_q;
  assign load_err      = err_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: hand sequences, a vector table and
// randomized frames checked against a frame-parsing reference model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int TMO = 16;

  typedef logic [IMEM_ADDR_W+31:0] wr_t;

  typedef struct {
    string        name;
    int           n;
    logic [127:0] bytes;
    int           ww;
    bit           done;
    bit           err;
    bit           hold;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_hold, load_done, load_err;
  logic [15:0] words_written;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(IMEM_ADDR_W)) bus ();

  imem_loader #(
    .DEPTH     (IMEM_DEPTH),
    .ADDR_W    (IMEM_ADDR_W),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (TMO),
    .BOOT_HOLD (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
    .load_err      (load_err),
    .words_written (words_written)
  );

  // Write monitor, sampled just after each rising edge.
  wr_t  got_q[$];
  logic prev_we = 1'b0;
  int   we_double = 0;
  always @(posedge clk) begin
    #1;
    if (bus.mem_we) got_q.push_back({bus.mem_waddr, bus.mem_wdata});
    if (bus.mem_we && prev_we) we_double++;
    prev_we = bus.mem_we;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic send(input bit v, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 8'h00);
  endtask

  task automatic check_writes(input string nm, input wr_t exp[$]);
    int n;
    check({nm, "_nwrites"}, 64'(got_q.size()), 64'(exp.size()));
    n = (got_q.size() < exp.size()) ? got_q.size() : exp.size();
    for (int i = 0; i < n; i++) check({nm, "_write"}, 64'(got_q[i]), 64'(exp[i]));
    got_q.delete();
  endtask

  // Reference: skip to each sync byte, read the count, slice the following
  // bytes into little-endian words, keep those that land inside the memory.
  function automatic void model(input logic [7:0] s[$], output wr_t exp[$], output int ww);
    int i = 0;
    int cnt;
    exp.delete();
    ww = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
      end else if (i + 2 >= s.size()) begin
        i = s.size();
      end else begin
        cnt = int'(s[i+1]) + 256 * int'(s[i+2]);
        i  += 3;
        ww  = 0;
        for (int w = 0; w < cnt && i + 3 < s.size(); w++) begin
          if (w < IMEM_DEPTH) begin
            exp.push_back({IMEM_ADDR_W'(w), s[i+3], s[i+2], s[i+1], s[i]});
            ww++;
          end
          i += 4;
        end
      end
    end
  endfunction

  task automatic check_status(input string nm, input int ww, input bit done, input bit err, input bit hold);
    check({nm, "_ww"},   64'(words_written), 64'(ww));
    check({nm, "_done"}, 64'(load_done),     64'(done));
    check({nm, "_err"},  64'(load_err),      64'(err));
    check({nm, "_hold"}, 64'(cpu_hold),      64'(hold));
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_we"},    64'(bus.mem_we),    64'd0);
    check({nm, "_waddr"}, 64'(bus.mem_waddr), 64'd0);
    check({nm, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({nm, "_ready"}, 64'(bus.in_ready),  64'd1);
    check_status(nm, 0, 1'b0, 1'b0, 1'b1);
  endtask

  vec_t        vecs[5];
  logic [7:0]  s[$];
  wr_t         exp[$];
  int          mww;
  logic [7:0]  b;

  initial begin
    vecs[0] = '{"noise_done",   3,  128'h00_FF_12, 2, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"count0",       3,  128'hA5_00_00, 0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"noise_done2",  3,  128'h00_FF_12, 0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"sync_in_data", 7,  128'hA5_01_00_A5_A5_A5_A5, 1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"three_words",  15, 128'hA5_03_00_01_02_03_04_05_06_07_08_09_0A_0B_0C,
                3, 1'b1, 1'b0, 1'b0};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Noise in IDLE is ignored.
    send(1'b1, 8'h00); send(1'b1, 8'hFF); send(1'b1, 8'h12);
    idle(2);
    check_status("noise_idle", 0, 1'b0, 1'b0, 1'b1);
    exp.delete();
    check_writes("noise_idle", exp);

    // Two-word boot image with release timing.
    s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    foreach (s[i]) send(1'b1, s[i]);
    bus.in_valid = 1'b0;
    check("basic_last_we",     64'(bus.mem_we), 64'd1);
    check("basic_done_early",  64'(load_done),  64'd0);
    check("basic_hold_early",  64'(cpu_hold),   64'd1);
    idle(1);
    check("basic_done_k2", 64'(load_done), 64'd1);
    check("basic_hold_k2", 64'(cpu_hold),  64'd0);
    exp = '{{10'd0, 32'h00000013}, {10'd1, 32'h00100093}};
    check_writes("basic", exp);
    check("basic_ww", 64'(words_written), 64'd2);

    // Vector table.
    for (int v = 0; v < 5; v++) begin
      s.delete();
      for (int i = 0; i < vecs[v].n; i++) s.push_back(vecs[v].bytes[8*(vecs[v].n-1-i) +: 8]);
      model(s, exp, mww);
      foreach (s[i]) send(1'b1, s[i]);
      idle(3);
      check_writes(vecs[v].name, exp);
      check_status(vecs[v].name, vecs[v].ww, vecs[v].done, vecs[v].err, vecs[v].hold);
    end

    // Oversized frame: 1026 words back to back, last two dropped.
    s = '{8'hA5, 8'h02, 8'h04};
    for (int i = 0; i < 4 * 1026; i++) s.push_back(8'($urandom));
    model(s, exp, mww);
    foreach (s[i]) send(1'b1, s[i]);
    idle(3);
    check_writes("big", exp);
    check_status("big", 1024, 1'b1, 1'b0, 1'b0);

    // Timeout after two data bytes.
    s = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
    foreach (s[i]) send(1'b1, s[i]);
    idle(TMO - 1);
    check("tmo_err_early", 64'(load_err), 64'd0);
    idle(1);
    check("tmo_err", 64'(load_err), 64'd1);
    idle(2);
    exp.delete();
    check_writes("tmo", exp);
    check_status("tmo", 0, 1'b0, 1'b1, 1'b1);
    s = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    foreach (s[i]) send(1'b1, s[i]);
    idle(3);
    exp = '{{10'd0, 32'h12345678}};
    check_writes("after_tmo", exp);
    check_status("after_tmo", 1, 1'b1, 1'b0, 1'b0);

    // Randomized frames with noise and sub-timeout gaps.
    for (int it = 0; it < 25; it++) begin
      s.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        s.push_back((b == 8'hA5) ? 8'h5A : b);
      end
      mww = $urandom_range(0, 5);
      s.push_back(8'hA5);
      s.push_back(8'(mww));
      s.push_back(8'h00);
      repeat (4 * mww) s.push_back(8'($urandom));
      model(s, exp, mww);
      foreach (s[i]) begin
        idle($urandom_range(0, 3));
        send(1'b1, s[i]);
      end
      idle(3);
      check_writes("rand", exp);
      check_status("rand", mww, 1'b1, 1'b0, 1'b0);
    end

    // Reset asserted mid-word discards the frame.
    s = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    foreach (s[i]) send(1'b1, s[i]);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1, 8'h33); send(1'b1, 8'h44);
    idle(3);
    exp.delete();
    check_writes("post_rst", exp);
    check_status("post_rst", 0, 1'b0, 1'b0, 1'b1);

    check("no_back_to_back_we", 64'(we_double), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the processor's 1024×32 instruction memory.
- Takes a byte stream from a serial receiver (valid/ready), frames it as sync byte, 16-bit word count, then little-endian instruction words.
- Drives the instruction-RAM write port and holds the CPU in reset until the load completes.
- Sits between the UART receiver and the instruction memory write side; the CPU read/fetch side is untouched.

Parameters:
- DEPTH, 1024, instruction memory depth in 32-bit words.
- ADDR_W, 10, word-address width (clog2 DEPTH).
- SYNC_BYTE, 8'hA5, byte that starts a load frame.
- TIMEOUT, 1000000, max clk cycles between bytes inside a frame before abort.
- BOOT_HOLD, 1, 1 = cpu_hold asserted out of reset; 0 = cpu_hold low out of reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  received byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte; a byte transfers when in_valid && in_ready.
- mem_we  out  1  one-cycle write strobe to instruction RAM.
- mem_waddr  out  ADDR_W  word address of write.
- mem_wdata  out  32  instruction word.
- cpu_hold  out  1  holds CPU (PC reset) while high.
- load_done  out  1  last frame completed successfully.
- load_err  out  1  last frame aborted by timeout.
- words_written  out  16  words actually written in current/last frame.

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_we=0, mem_waddr=0, mem_wdata=0, load_done=0, load_err=0, words_written=0, cpu_hold=BOOT_HOLD; byte/word/timeout counters cleared. Reset mid-frame discards the frame with no further writes.
- in_ready=1 in every state; no backpressure.
- States: IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR.
- IDLE/DONE/ERR: a byte == SYNC_BYTE goes to LEN_LO, sets cpu_hold=1, clears load_done, load_err and words_written. Other bytes are ignored.
- LEN_LO: the byte becomes count[7:0], then go to LEN_HI.
- LEN_HI: the byte becomes count[15:8]. If the 16-bit count is 0, go to DONE. Otherwise go to DATA with word index 0 and byte lane 0.
- DATA, byte assembly: little-endian, so byte lane 0 goes to bits [7:0] and lane 3 to bits [31:24].
- DATA, on lane-3 accept at cycle k: at k+1, mem_we=1, mem_waddr=word index[ADDR_W-1:0], mem_wdata=assembled word. Write latency is one cycle. A byte of the next word may be accepted at k+1 without corruption.
- Words with index >= DEPTH are consumed but not written (mem_we stays 0). words_written counts only real writes and saturates at DEPTH.
- Last word of count accepted at cycle k: write at k+1, state DONE at k+1. load_done=1 and cpu_hold=0 at k+2, so the CPU is released only after the final write has committed.
- Timeout: in LEN_LO, LEN_HI or DATA, a counter increments on each cycle without an accepted byte and resets to 0 on an accept. When it reaches TIMEOUT, go to ERR: load_err=1, cpu_hold stays 1, any partial word is discarded, and words already written remain.
- A sync byte received inside a frame is treated as data, not a restart.
- Outputs are registered; mem_we is never high for two consecutive cycles.

Decomposition:
- Shared package holds:
  - state enum (IDLE..ERR)
  - SYNC_BYTE default
  - IMEM_DEPTH = 1024 and IMEM_ADDR_W = 10, also used by the instruction memory
- One natural sub-module, imem_byte_packer: lane counter plus 32-bit shift/assembly register, emitting word_valid and word. The FSM, counters and timeout stay in imem_loader.

Test Plan:
- Reset with BOOT_HOLD=1, then stream A5 02 00 13 00 00 00 93 00 10 00 -> mem_we pulses at word addresses 0 and 1 with 32'h00000013 and 32'h00100093; words_written=2; load_done=1 and cpu_hold=0 two cycles after the last byte.
- Stream A5 00 00 -> no mem_we; load_done=1, cpu_hold=0; words_written=0.
- Count 1026 (A5 02 04), bytes back-to-back every cycle -> exactly 1024 writes at addresses 0..1023, none for words 1024/1025; words_written=1024; load_done=1.
- TIMEOUT=16: A5 01 00 AA BB, then idle -> load_err=1 after 16 idle cycles; no mem_we; cpu_hold=1; a following A5 01 00 + 4 bytes loads normally and clears load_err.
- Assert rst_n=0 mid-DATA after 2 of 4 bytes -> all outputs return to reset values asynchronously; no write occurs after reset release.
- Noise bytes 00 FF 12 while in IDLE or DONE -> ignored: state, cpu_hold, load_done and memory writes unchanged.
